register_bank_mp: RTL

Parametrised multi-port register bank: the next generation of the datapath's 8×16 register bank. One synchronous write port and two independent registered read ports, with same-cycle write-to-read bypass, an optional hardwired-zero register 0, and a hardware clear sequencer that zeroes every register over NREGS cycles. It sits between the control unit's register-select fields and the internal buses, replacing the decoder-plus-tristate register bank.

---
 rtl/register_bank_mp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/register_bank_mp.sv
// register_bank_mp: parametrised register bank with one write port, two
// registered read ports, same-cycle write-to-read bypass, an optional
// hardwired-zero register 0 and a sequencer that zeroes every register
// one per cycle.
module register_bank_mp #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              busy_nxt;
  logic [DATA_W-1:0] regs [NREGS];

  logic wr_eff;
  logic clr_act;
  logic cnt_last;

  // Address lies inside the implemented register range.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NREGS);
  endfunction

  // Address refers to the hardwired-zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Value a read port captures this edge: the clear write and a real
  // write both bypass, and unimplemented or hardwired addresses give 0.
  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] a);
    if (!in_range(a) || is_zero_reg(a)) return '0;
    if (clr_act && (cnt == a))          return '0;
    if (wr_eff && (wr_addr == a))       return wr_data;
    return regs[a];
  endfunction

  // Writes are only honoured while the sweep is idle.
  assign clr_act  = (state == CLEAR);
  assign wr_eff   = wr_en && !clr_act && in_range(wr_addr) && !is_zero_reg(wr_addr);
  assign cnt_last = (32'(cnt) == 32'(NREGS - 1));

  // Clear sequencer next-state: IDLE waits for clr_req, CLEAR walks cnt once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt_last) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt == CLEAR);
  end

  // Clear sequencer state, sweep counter and busy flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
    end
  end

  // Register storage: the sweep owns the write path while it runs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_act) begin
      regs[cnt] <= '0;
    end else if (wr_eff) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Registered read ports; each holds its value while its strobe is low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (rd_en_a) rd_data_a <= read_mux(rd_addr_a);
      if (rd_en_b) rd_data_b <= read_mux(rd_addr_b);
    end
  end

endmodule
